systolic_row_feeder: RTL and testbench

//  Sits directly upstream of the PE array. It takes one activation vector per cycle from the input buffer.
//  It emits each vector diagonally skewed: row r is delayed r cycles.
//  The skewed outputs drive in_left and go of the PE in column 0 of each row.
//  A start/done frame controls one matrix pass; PE timing is kept intact when the buffer starves.

---
 rtl/tpu_pkg.sv | 26 ++
 rtl/systolic_row_feeder_if.sv | 30 +++
 rtl/skew_delay_line.sv | 36 +++
 rtl/systolic_row_feeder.sv | 140 ++++++++++++++
 tb/tb_systolic_row_feeder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU types and default sizes for the row feeder and PE array
//
// Contents:
//   DATA_SIZE_W    element width, taken from `DATA_SIZE (8 when the define is absent)
//   PE_ROWS        number of PE rows in the array, also the feeder's default row count
//   FEED_CNT_W     default width of the feeder's vector and bubble counters
//   feeder_state_t row feeder FSM state (IDLE/FEED/DRAIN/DONE)

`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

package tpu_pkg;

  localparam int DATA_SIZE_W = `DATA_SIZE;
  localparam int PE_ROWS     = 4;
  localparam int FEED_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/systolic_row_feeder_if.sv
// rtl/systolic_row_feeder_if.sv - activation vector handshake from the input buffer to the row feeder
//
// Signals:
//   in_valid  master -> slave  in_vec holds a valid activation vector
//   in_ready  slave  -> master feeder takes in_vec this cycle
//   in_vec    master -> slave  ROWS elements, element r at [r*DATA_W +: DATA_W]
// Modports: master (input buffer side), slave (feeder side).

interface systolic_row_feeder_if #(
  parameter int ROWS   = tpu_pkg::PE_ROWS,
  parameter int DATA_W = tpu_pkg::DATA_SIZE_W
);

  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] in_vec;

  modport master (
    output in_valid,
    output in_vec,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    output in_ready
  );

endinterface

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - DEPTH-stage shift register with synchronous clear
//
// Ports:
//   clk  in  1  clock
//   clr  in  1  synchronous clear of every stage
//   d    in  W  value entering stage 0
//   q    out W  last stage; shows d from DEPTH edges after it was presented

module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_row_feeder.sv
// rtl/systolic_row_feeder.sv - skews activation vectors diagonally onto the PE array rows
//
// Optional feature macro: FEEDER_BUBBLE_CNT_EN (adds the bubble_cnt port and counter).
//
// Ports:
//   clk         in   1            clock
//   rst         in   1            synchronous active-high reset; aborts a pass without done
//   start       in   1            begin a pass, honoured only while idle
//   num_vec     in   CNT_W        vectors in the pass, latched with start
//   in_if       slave             in_valid / in_ready / in_vec from the input buffer
//   row_data    out  ROWS*DATA_W  skewed elements, row r at [r*DATA_W +: DATA_W]
//   row_go      out  ROWS         per-row go to PE column 0
//   busy        out  1            pass in progress (feeding or draining)
//   done        out  1            one-cycle pulse once the last element has left row ROWS-1
//   bubble_cnt  out  CNT_W        feed cycles with no vector offered (macro only)

module systolic_row_feeder
  import tpu_pkg::*;
#(
  parameter int ROWS   = PE_ROWS,
  parameter int DATA_W = DATA_SIZE_W,
  parameter int CNT_W  = FEED_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vec,
  systolic_row_feeder_if.slave   in_if,
  output logic [ROWS*DATA_W-1:0] row_data,
  output logic [ROWS-1:0]        row_go,
  output logic                   busy,
  output logic                   done
`ifdef FEEDER_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0]       bubble_cnt
`endif
);

  localparam int DRAIN_W = $clog2(ROWS);

  feeder_state_t      state;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   vec_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept;

  assign in_if.in_ready = (state == ST_FEED);
  assign accept         = in_if.in_valid & in_if.in_ready;

  // Pass control. DRAIN spans ROWS cycles so that DONE lands on the cycle
  // after the deepest row has shown the final element.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      num_q     <= '0;
      vec_cnt   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            num_q   <= num_vec;
            vec_cnt <= '0;
            if (num_vec == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FEED;
              busy  <= 1'b1;
            end
          end
        end
        ST_FEED: begin
          if (accept) begin
            if (vec_cnt != num_q) begin
              vec_cnt <= vec_cnt + CNT_W'(1);
            end
            if (vec_cnt + CNT_W'(1) == num_q) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_W'(ROWS - 1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FEEDER_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      bubble_cnt <= '0;
    end else if (state == ST_FEED && !in_if.in_valid && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

  // Every cycle pushes a slot into all rows; a cycle without an accepted
  // vector pushes a zero bubble so the array keeps its timing.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W:0] slot;
    logic [DATA_W:0] tap;

    assign slot = accept ? {1'b1, in_if.in_vec[r*DATA_W +: DATA_W]} : '0;

    skew_delay_line #(
      .DEPTH (r + 1),
      .W     (DATA_W + 1)
    ) u_skew (
      .clk (clk),
      .clr (rst),
      .d   (slot),
      .q   (tap)
    );

    assign row_data[r*DATA_W +: DATA_W] = tap[DATA_W-1:0];
    assign row_go[r]                    = tap[DATA_W];
  end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// tb/tb_systolic_row_feeder.sv - self-checking bench for systolic_row_feeder

module tb_systolic_row_feeder;

  localparam int ROWS   = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int VW     = ROWS * DATA_W;
  localparam int LOGN   = 1024;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             start   = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic [VW-1:0]    row_data;
  logic [ROWS-1:0]  row_go;
  logic             busy;
  logic             done;
`ifdef FEEDER_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt;
`endif

  systolic_row_feeder_if #(.ROWS(ROWS), .DATA_W(DATA_W)) in_if ();

  systolic_row_feeder #(.ROWS(ROWS), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_vec  (num_vec),
    .in_if    (in_if),
    .row_data (row_data),
    .row_go   (row_go),
    .busy     (busy),
    .done     (done)
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Behavioural model: a log of what was pushed each cycle plus the pass timeline.
  int            cyc = 0;
  logic [VW-1:0] hist_vec [LOGN];
  logic          hist_go  [LOGN];
  int            hist_base = 0;
  bit            m_feed    = 0;
  int            m_left    = 0;
  int            m_done_at = -1;
  int            m_busy_to = -1;
  int            m_idle_at = 0;
  int            m_bub     = 0;

  logic [VW-1:0]   log_row  [LOGN];
  logic [ROWS-1:0] log_go   [LOGN];
  logic            log_done [LOGN];
  logic            log_busy [LOGN];
  logic            log_rdy  [LOGN];

  logic [VW-1:0]   exp_data;
  logic [ROWS-1:0] exp_go;
  int              src;

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= LOGN) begin
        errors++;
        $display("FAIL cycle_budget: got %0d expected below %0d", cyc, LOGN);
        $fatal(1, "cycle budget exhausted");
      end
      exp_data = '0;
      exp_go   = '0;
      for (int r = 0; r < ROWS; r++) begin
        src = cyc - 1 - r;
        if (src >= 0 && src >= hist_base && hist_go[src]) begin
          exp_go[r] = 1'b1;
          exp_data[r*DATA_W +: DATA_W] = hist_vec[src][r*DATA_W +: DATA_W];
        end
      end
      chk("row_data", 64'(row_data), 64'(exp_data));
      chk("row_go", 64'(row_go), 64'(exp_go));
      chk("in_ready", 64'(in_if.in_ready), 64'(m_feed));
      chk("busy", 64'(busy), 64'(m_feed || cyc <= m_busy_to));
      chk("done", 64'(done), 64'(cyc == m_done_at));
`ifdef FEEDER_BUBBLE_CNT_EN
      chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
`endif
      log_row[cyc]  = row_data;
      log_go[cyc]   = row_go;
      log_done[cyc] = done;
      log_busy[cyc] = busy;
      log_rdy[cyc]  = in_if.in_ready;

      hist_go[cyc]  = 1'b0;
      hist_vec[cyc] = '0;
      if (rst) begin
        hist_base = cyc + 1;
        m_feed    = 0;
        m_left    = 0;
        m_done_at = -1;
        m_busy_to = -1;
        m_idle_at = cyc + 1;
        m_bub     = 0;
      end else if (m_feed) begin
        if (in_if.in_valid) begin
          hist_go[cyc]  = 1'b1;
          hist_vec[cyc] = in_if.in_vec;
          m_left--;
          if (m_left == 0) begin
            m_feed    = 0;
            m_busy_to = cyc + ROWS;
            m_done_at = cyc + ROWS + 1;
            m_idle_at = cyc + ROWS + 2;
          end
        end else if (m_bub < 65535) begin
          m_bub++;
        end
      end else if (start && cyc >= m_idle_at) begin
        m_bub = 0;
        if (num_vec == '0) begin
          m_done_at = cyc + 1;
          m_idle_at = cyc + 2;
        end else begin
          m_feed    = 1;
          m_left    = int'(num_vec);
          m_idle_at = 4 * LOGN;
        end
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s;
  int n;

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_vec   = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1: reset mid-FEED
    s = cyc;
    start = 1'b1; num_vec = 16'd5;
    tick();
    start = 1'b0; in_if.in_valid = 1'b1; in_if.in_vec = vec4(21, 22, 23, 24);
    tick();
    in_if.in_vec = vec4(25, 26, 27, 28);
    tick();
    s = cyc;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0; in_if.in_valid = 1'b0;
    repeat (10) tick();
    chk("t1_row_data", 64'(log_row[s+1]), 64'h0);
    chk("t1_row_go", 64'(log_go[s+1]), 64'h0);
    chk("t1_busy", 64'(log_busy[s+1]), 64'h0);
    chk("t1_ready", 64'(log_rdy[s+1]), 64'h0);
    n = 0;
    for (int i = s; i <= s + 10; i++) n += int'(log_done[i]);
    chk("t1_no_done", 64'(n), 64'd0);

    // 2: three vectors back to back
    s = cyc;
    start = 1'b1; num_vec = 16'd3;
    tick();
    start = 1'b0; in_if.in_valid = 1'b1; in_if.in_vec = vec4(1, 2, 3, 4);
    tick();
    in_if.in_vec = vec4(5, 6, 7, 8);
    tick();
    in_if.in_vec = vec4(9, 10, 11, 12);
    tick();
    in_if.in_valid = 1'b0;
    repeat (10) tick();
    chk("t2_row0_c1", 64'(log_row[s+2][7:0]), 64'd1);
    chk("t2_row0_c2", 64'(log_row[s+3][7:0]), 64'd5);
    chk("t2_row0_c3", 64'(log_row[s+4][7:0]), 64'd9);
    chk("t2_row3_c4", 64'(log_row[s+5][31:24]), 64'd4);
    chk("t2_row3_c5", 64'(log_row[s+6][31:24]), 64'd8);
    chk("t2_row3_c6", 64'(log_row[s+7][31:24]), 64'd12);
    chk("t2_go3_c4", 64'(log_go[s+5][3]), 64'd1);
    chk("t2_go3_c7", 64'(log_go[s+8][3]), 64'd0);
    chk("t2_done_c6", 64'(log_done[s+7]), 64'd0);
    chk("t2_done_c7", 64'(log_done[s+8]), 64'd1);
    chk("t2_busy_c8", 64'(log_busy[s+9]), 64'd0);

    // 3: starved second FEED cycle
    s = cyc;
    start = 1'b1; num_vec = 16'd3;
    tick();
    start = 1'b0; in_if.in_valid = 1'b1; in_if.in_vec = vec4(1, 2, 3, 4);
    tick();
    in_if.in_valid = 1'b0;
    tick();
    in_if.in_valid = 1'b1; in_if.in_vec = vec4(5, 6, 7, 8);
    tick();
    in_if.in_vec = vec4(9, 10, 11, 12);
    tick();
    in_if.in_valid = 1'b0;
    repeat (10) tick();
    chk("t3_row0_bubble", 64'(log_row[s+3][7:0]), 64'd0);
    chk("t3_go0_bubble", 64'(log_go[s+3][0]), 64'd0);
    chk("t3_row0_late", 64'(log_row[s+4][7:0]), 64'd5);
    chk("t3_go3_bubble", 64'(log_go[s+6][3]), 64'd0);
    chk("t3_row3_late", 64'(log_row[s+8][31:24]), 64'd12);
    chk("t3_done_c7", 64'(log_done[s+8]), 64'd0);
    chk("t3_done_c8", 64'(log_done[s+9]), 64'd1);
`ifdef FEEDER_BUBBLE_CNT_EN
    chk("t3_bubble_cnt", 64'(bubble_cnt), 64'd1);
`endif

    // 4: empty pass
    s = cyc;
    start = 1'b1; num_vec = 16'd0; in_if.in_valid = 1'b1; in_if.in_vec = vec4(7, 7, 7, 7);
    tick();
    start = 1'b0;
    repeat (6) tick();
    in_if.in_valid = 1'b0;
    chk("t4_done", 64'(log_done[s+1]), 64'd1);
    n = 0;
    for (int i = s; i <= s + 5; i++) n += int'(log_rdy[i]) + int'(|log_go[i]) + int'(log_done[i]);
    chk("t4_quiet", 64'(n), 64'd1);

    // 5: start while busy is ignored
    s = cyc;
    start = 1'b1; num_vec = 16'd2;
    tick();
    start = 1'b0; in_if.in_valid = 1'b1; in_if.in_vec = vec4(31, 32, 33, 34);
    tick();
    start = 1'b1; num_vec = 16'd7; in_if.in_vec = vec4(35, 36, 37, 38);
    tick();
    in_if.in_vec = vec4(39, 40, 41, 42);
    tick();
    in_if.in_valid = 1'b0;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("t5_no_third", 64'(log_go[s+4][0]), 64'd0);
    chk("t5_done", 64'(log_done[s+7]), 64'd1);
    n = 0;
    for (int i = s; i <= s + 12; i++) n += int'(log_done[i]);
    chk("t5_one_done", 64'(n), 64'd1);
    chk("t5_idle", 64'(log_busy[s+9]), 64'd0);

    // 6: start during DONE ignored, next cycle honoured
    s = cyc;
    start = 1'b1; num_vec = 16'd1;
    tick();
    start = 1'b0; in_if.in_valid = 1'b1; in_if.in_vec = vec4(51, 52, 53, 54);
    tick();
    in_if.in_valid = 1'b0;
    repeat (4) tick();
    start = 1'b1; num_vec = 16'd2;
    tick();
    tick();
    start = 1'b0; in_if.in_valid = 1'b1; in_if.in_vec = vec4(61, 62, 63, 64);
    tick();
    in_if.in_vec = vec4(65, 66, 67, 68);
    tick();
    in_if.in_valid = 1'b0;
    repeat (10) tick();
    chk("t6_done1", 64'(log_done[s+6]), 64'd1);
    chk("t6_ignored", 64'(log_busy[s+7]), 64'd0);
    chk("t6_busy2", 64'(log_busy[s+8]), 64'd1);
    chk("t6_row0", 64'(log_row[s+9][7:0]), 64'd61);
    chk("t6_row3", 64'(log_row[s+12][31:24]), 64'd64);
    chk("t6_done2", 64'(log_done[s+14]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
